// File: rtl/traffic_pkg.sv
// ============================================================================
// Module   : traffic_pkg
// Purpose  : Shared types and default constants for the traffic-light panel
//            front-end blocks (pedestrian request, button debounce).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

    // Debounce FSM states. Encoding is fixed at 2 bits.
    typedef enum logic [1:0] {
        DB_IDLE     = 2'd0,
        DB_CHECK_HI = 2'd1,
        DB_HELD     = 2'd2,
        DB_CHECK_LO = 2'd3
    } db_state_t;

    localparam int PED_DEBOUNCE_DEFAULT = 16;
    localparam int PED_LOCKOUT_DEFAULT  = 64;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Purpose  : Two-flop synchronizer plus press/release debounce FSM for a raw
//            panel push-button. Emits a single-cycle press_accept per
//            debounced press; a new press needs a debounced release first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = PED_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic press_accept
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Counter width collapses below two cycles, so refuse such builds.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2");
    end

    logic             sync_meta;
    logic             btn_sync;
    db_state_t        state;
    db_state_t        state_next;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] cnt_next;

    // Bring the asynchronous button level into the clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b0;
            btn_sync  <= 1'b0;
        end else begin
            sync_meta <= button;
            btn_sync  <= sync_meta;
        end
    end

    // Debounce state and stability counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= DB_IDLE;
            db_cnt <= '0;
        end else begin
            state  <= state_next;
            db_cnt <= cnt_next;
        end
    end

    // Next-state logic: count consecutive stable samples in each direction.
    always_comb begin
        state_next   = state;
        cnt_next     = db_cnt;
        press_accept = 1'b0;
        case (state)
            DB_IDLE: begin
                if (btn_sync) begin
                    state_next = DB_CHECK_HI;
                    cnt_next   = '0;
                end
            end
            DB_CHECK_HI: begin
                if (!btn_sync) begin
                    state_next = DB_IDLE;
                end else if (db_cnt == CNT_LAST) begin
                    state_next   = DB_HELD;
                    press_accept = 1'b1;
                end else begin
                    cnt_next = db_cnt + CNT_ONE;
                end
            end
            DB_HELD: begin
                if (!btn_sync) begin
                    state_next = DB_CHECK_LO;
                    cnt_next   = '0;
                end
            end
            DB_CHECK_LO: begin
                if (btn_sync) begin
                    state_next = DB_HELD;
                end else if (db_cnt == CNT_LAST) begin
                    state_next = DB_IDLE;
                end else begin
                    cnt_next = db_cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = DB_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ped_request_ctrl.sv
// ============================================================================
// Module   : ped_request_ctrl
// Purpose  : Pedestrian request front-end. Debounces the crosswalk button,
//            latches one request until the controller reports PED service,
//            and pulses pedToggle once per newly latched request.
// Config   : define PED_LOCKOUT_EN to discard presses for LOCKOUT_CYCLES
//            after each pedServed pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ped_request_ctrl
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = PED_DEBOUNCE_DEFAULT,
    parameter int LOCKOUT_CYCLES  = PED_LOCKOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic pedButton,
    input  logic pedServed,
    output logic pedToggle,
    output logic pedRequest,
    output logic waitLight
);

    if (LOCKOUT_CYCLES < 1) begin : g_bad_lockout
        $error("ped_request_ctrl: LOCKOUT_CYCLES must be >= 1");
    end

    logic press_accept;
    logic locked;
    logic set_req;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk          (clk),
        .reset        (reset),
        .button       (pedButton),
        .press_accept (press_accept)
    );

`ifdef PED_LOCKOUT_EN
    localparam int              LOCK_W   = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES);
    localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);

    logic [LOCK_W-1:0] lock_cnt;

    // Post-service lockout window; reloads on every service pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_cnt <= '0;
        end else if (pedServed) begin
            lock_cnt <= LOCK_LOAD;
        end else if (lock_cnt != '0) begin
            lock_cnt <= lock_cnt - LOCK_ONE;
        end
    end

    assign locked = (lock_cnt != '0);
`else
    assign locked = 1'b0;
`endif

    // A press only latches a fresh request; service in the same cycle absorbs it.
    assign set_req = press_accept && !locked && !pedServed && !pedRequest;

    // Request latch with clear priority, and the 0->1 toggle pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pedRequest <= 1'b0;
            pedToggle  <= 1'b0;
        end else begin
            if (pedServed) begin
                pedRequest <= 1'b0;
            end else if (set_req) begin
                pedRequest <= 1'b1;
            end
            pedToggle <= set_req;
        end
    end

    assign waitLight = pedRequest;

endmodule

`default_nettype wire

// File: tb/tb_ped_request_ctrl.sv
// ============================================================================
// Module   : tb_ped_request_ctrl
// Purpose  : Self-checking bench for ped_request_ctrl (DEBOUNCE=4, LOCKOUT=8).
//            Directed scenarios with literal expectations, then random
//            button/service/reset traffic against a streak-count model.
// Config   : honours PED_LOCKOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ped_request_ctrl;

    localparam int D  = 4;
    localparam int LK = 8;
`ifdef PED_LOCKOUT_EN
    localparam logic LOCK_ON = 1'b1;
`else
    localparam logic LOCK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic pedButton;
    logic pedServed;
    logic pedToggle;
    logic pedRequest;
    logic waitLight;

    int checks   = 0;
    int failures = 0;

    logic lit_en;
    logic lit_req;
    logic lit_tog;

    ped_request_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .LOCKOUT_CYCLES (LK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pedButton  (pedButton),
        .pedServed  (pedServed),
        .pedToggle  (pedToggle),
        .pedRequest (pedRequest),
        .waitLight  (waitLight)
    );

    always #5 clk = ~clk;

    // Reference model: the debounced level flips once the synchronized input
    // has disagreed with it for D+1 consecutive cycles; a 0->1 flip is a press.
    logic m_sync1, m_sync2, m_level, m_req, m_tog;
    int   m_streak;
`ifdef PED_LOCKOUT_EN
    int   m_lock;
`endif

    always @(posedge clk or posedge reset) begin : model
        logic accept;
        logic blocked;
        logic set_req;
        if (reset) begin
            m_sync1 = 1'b0; m_sync2 = 1'b0; m_level = 1'b0;
            m_req = 1'b0; m_tog = 1'b0; m_streak = 0;
`ifdef PED_LOCKOUT_EN
            m_lock = 0;
`endif
        end else begin
            if (m_sync2 != m_level) m_streak = m_streak + 1;
            else                    m_streak = 0;
            accept = 1'b0;
            if (m_streak == D + 1) begin
                accept   = !m_level;
                m_level  = !m_level;
                m_streak = 0;
            end
`ifdef PED_LOCKOUT_EN
            blocked = (m_lock != 0);
`else
            blocked = 1'b0;
`endif
            set_req = accept && !blocked && !pedServed && !m_req;
            m_tog   = set_req;
            if (pedServed)    m_req = 1'b0;
            else if (set_req) m_req = 1'b1;
`ifdef PED_LOCKOUT_EN
            if (pedServed)       m_lock = LK;
            else if (m_lock > 0) m_lock = m_lock - 1;
`endif
            m_sync2 = m_sync1;
            m_sync1 = pedButton;
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, exp);
        end
    endtask

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        check("pedRequest", pedRequest, m_req);
        check("pedToggle",  pedToggle,  m_tog);
        check("waitLight",  waitLight,  m_req);
        if (lit_en) begin
            check("lit_pedRequest", pedRequest, lit_req);
            check("lit_pedToggle",  pedToggle,  lit_tog);
            check("lit_waitLight",  waitLight,  lit_req);
        end
    end

    // Drive one cycle; the literal describes outputs after the sampling edge.
    task automatic cyc(input logic btn, input logic srv,
                       input logic le, input logic lreq, input logic ltog);
        pedButton = btn;
        pedServed = srv;
        @(posedge clk);
        #1;
        lit_en  = le;
        lit_req = lreq;
        lit_tog = ltog;
    endtask

    task automatic idle_cycles(input int n, input logic lreq);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b1, lreq, 1'b0);
    endtask

    task automatic pulse_reset();
        reset     = 1'b1;
        pedServed = 1'b0;
        lit_en    = 1'b1;
        lit_req   = 1'b0;
        lit_tog   = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic bounce [5];
    logic rb;
    logic rs;

    initial begin
        bounce    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        pedButton = 1'b0;
        pedServed = 1'b0;
        reset     = 1'b0;
        lit_en    = 1'b0;
        lit_req   = 1'b0;
        lit_tog   = 1'b0;

        // Reset state
        #1;
        reset  = 1'b1;
        lit_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Clean press: request and single toggle after edge 7
        for (int i = 1; i <= 20; i++) cyc(1'b1, 1'b0, 1'b1, i >= 7, i == 7);
        idle_cycles(10, 1'b1);

        // Service, then a press completing 3 cycles after service
        for (int i = 1; i <= 10; i++) begin
            if (i < 4)       cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            else if (i == 4) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            else if (i < 7)  cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            else             cyc(1'b1, 1'b0, 1'b1, !LOCK_ON, (i == 7) && !LOCK_ON);
        end
        idle_cycles(10, !LOCK_ON);

        // Service, then a press completing 10 cycles after service
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle_cycles(3, 1'b0);
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 1'b1, i >= 7, i == 7);
        idle_cycles(10, 1'b1);

        // Press acceptance coincides with service: clear wins, no toggle
        for (int i = 1; i <= 9; i++) cyc(1'b1, i == 7, 1'b1, i < 7, 1'b0);
        idle_cycles(10, 1'b0);

        // Bounce then steady press
        for (int k = 0; k < 5; k++) cyc(bounce[k], 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 1'b1, i >= 7, i == 7);
        idle_cycles(10, 1'b1);

        // Glitch of 3 cycles never latches
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle_cycles(10, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_cycles(10, 1'b0);

        // Reset at edge 5 of a press, then again while a request is pending
        for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        pulse_reset();
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 1'b1, i >= 7, i == 7);
        pulse_reset();
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 1'b1, i >= 7, i == 7);
        idle_cycles(10, 1'b1);

        // Random traffic against the model only
        lit_en = 1'b0;
        rb = 1'b0;
        rs = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) rb = !rb;
            rs    = !rs && ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 599) == 0);
            pedButton = rb;
            pedServed = rs;
            @(posedge clk);
            #1;
            lit_en = 1'b0;
        end
        reset     = 1'b0;
        pedServed = 1'b0;

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
